md_unit: RTL

Multiply/divide controller for the 5-stage MIPS pipeline (P6). It accepts mult/multu/div/divu/mthi/mtlo from the E stage and models multi-cycle latency with a busy countdown. It owns the HI/LO registers and raises a D-stage stall request while any MD-class instruction would collide with an in-flight operation. It sits beside the ALU in E and feeds mfhi/mflo results into the E-stage result mux.

---
 rtl/md_unit_pkg.sv | 30 +++
 rtl/md_arith.sv | 62 ++++++
 rtl/md_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared opcode encodings, latency defaults and FSM state type for the
// multiply/divide unit.
package md_defs;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdState_t;

    // mult/multu/div/divu all live in the lower half of the opcode space
    function automatic logic isMulDiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic isDivOp(input logic [2:0] op);
        return (op[2] == 1'b0) && (op[1] == 1'b1);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational result generator: 64-bit product or quotient/remainder pair
// for one mult/multu/div/divu, plus a divide-by-zero flag.
module md_arith
    import md_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] resHi,
    output logic [31:0] resLo,
    output logic        div0
);

    logic [63:0] sProd;
    logic [63:0] uProd;

    // Explicit 64-bit extension keeps the multiplier width unambiguous
    assign sProd = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uProd = {32'd0, a} * {32'd0, b};

    always_comb begin
        resHi = '0;
        resLo = '0;
        div0  = 1'b0;
        case (op)
            MD_MULT: begin
                resHi = sProd[63:32];
                resLo = sProd[31:0];
            end
            MD_MULTU: begin
                resHi = uProd[63:32];
                resLo = uProd[31:0];
            end
            MD_DIV: begin
                if (b == 32'd0) begin
                    div0 = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    // The one signed overflow case: quotient wraps, remainder is zero
                    resLo = 32'h8000_0000;
                    resHi = 32'd0;
                end else begin
                    resLo = $signed(a) / $signed(b);
                    resHi = $signed(a) % $signed(b);
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    div0 = 1'b1;
                end else begin
                    resLo = a / b;
                    resHi = a % b;
                end
            end
            default: begin
                resHi = '0;
                resLo = '0;
                div0  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide controller: owns HI/LO, models multi-cycle latency with a
// countdown and requests a D-stage stall while MD instructions would collide.
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_in_d,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    mdState_t         state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic [31:0]      pendingHi_reg;
    logic [31:0]      pendingLo_reg;
    logic             pendingDiv0_reg;

    logic [31:0]      arithHi;
    logic [31:0]      arithLo;
    logic             arithDiv0;
    logic             startMulDiv;

    md_arith uArith (
        .op    (md_op),
        .a     (rs_val),
        .b     (rt_val),
        .resHi (arithHi),
        .resLo (arithLo),
        .div0  (arithDiv0)
    );

    assign startMulDiv = start && isMulDiv(md_op);

    // Result is computed up front; the countdown only models latency
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            busy_reg        <= 1'b0;
            hi_reg          <= '0;
            lo_reg          <= '0;
            pendingHi_reg   <= '0;
            pendingLo_reg   <= '0;
            pendingDiv0_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (startMulDiv) begin
                        pendingHi_reg   <= arithHi;
                        pendingLo_reg   <= arithLo;
                        pendingDiv0_reg <= arithDiv0;
                        cnt_reg         <= isDivOp(md_op) ? DIV_LOAD : MULT_LOAD;
                        busy_reg        <= 1'b1;
                        state_reg       <= ST_RUN;
                    end else if (start && md_op == MD_MTHI) begin
                        hi_reg <= rs_val;
                    end else if (start && md_op == MD_MTLO) begin
                        lo_reg <= rs_val;
                    end
                end
                ST_RUN: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                        // Divide by zero leaves HI/LO untouched
                        if (!pendingDiv0_reg) begin
                            hi_reg <= pendingHi_reg;
                            lo_reg <= pendingLo_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign stall_md = md_in_d && (busy_reg || startMulDiv);

endmodule
